md_seq_ctrl: RTL and testbench

MD_SEQ_CTRL -- requirements
Module: md_seq_ctrl

---
 rtl/md_seq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_md_seq_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_seq_ctrl.sv
// Multiply/divide sequencing controller for the execute stage.
// Latency: multiply done MUL_LAT cycles after request; divide done one cycle after dout_tvalid.
// Backpressure: done holds until req_accept; divider operands hold tvalid until their own tready.
module md_seq_ctrl #(
    parameter int MUL_LAT = 2    // legal range 1..7 (3-bit wait counter)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [1:0] req_kind,
    input  logic       req_accept,
    input  logic       flush,
    output logic       done,
    output logic       busy,
    output logic       sel_unsigned,
    output logic       dvd_tvalid,
    output logic       dvs_tvalid,
    input  logic       dvd_tready,
    input  logic       dvs_tready,
    input  logic       dout_tvalid
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MUL_WAIT  = 3'd1,
        ST_DIV_ISSUE = 3'd2,
        ST_DIV_WAIT  = 3'd3,
        ST_DONE      = 3'd4,
        ST_DRAIN     = 3'd5
    } state_t;

    // Counter value loaded on a multiply request; the wait state exits
    // when the counter is about to reach zero so that done rises exactly
    // MUL_LAT cycles after the request cycle.
    localparam logic [2:0] MUL_LOAD = 3'(MUL_LAT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] mul_cnt;
    logic       dvd_acc;
    logic       dvs_acc;
    logic       sel_q;

    logic       start_mul;
    logic       start_div;
    logic       dvd_hs;
    logic       dvs_hs;
    logic       dvd_now;
    logic       dvs_now;

    // Request decode is only consulted in IDLE; later changes are ignored.
    assign start_mul = req_valid && (req_kind == 2'b01);
    assign start_div = req_valid && req_kind[1];

    // A channel counts as accepted if it was accepted earlier or completes
    // its handshake this very cycle.
    assign dvd_hs  = dvd_tvalid && dvd_tready;
    assign dvs_hs  = dvs_tvalid && dvs_tready;
    assign dvd_now = dvd_acc || dvd_hs;
    assign dvs_now = dvs_acc || dvs_hs;

    // State register; reset abandons any divide in flight because the
    // divider IP shares the same reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (flush) begin
                    state_nxt = ST_IDLE;
                end else if (start_mul) begin
                    state_nxt = (MUL_LAT == 1) ? ST_DONE : ST_MUL_WAIT;
                end else if (start_div) begin
                    state_nxt = ST_DIV_ISSUE;
                end
            end
            ST_MUL_WAIT: begin
                if (flush) begin
                    state_nxt = ST_IDLE;
                end else if (mul_cnt <= 3'd1) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DIV_ISSUE: begin
                if (flush) begin
                    // Once any operand has been handed over the divider will
                    // eventually produce a result, which must be swallowed.
                    state_nxt = (dvd_now || dvs_now) ? ST_DRAIN : ST_IDLE;
                end else if (dvd_now && dvs_now) begin
                    state_nxt = ST_DIV_WAIT;
                end
            end
            ST_DIV_WAIT: begin
                if (flush) begin
                    state_nxt = dout_tvalid ? ST_IDLE : ST_DRAIN;
                end else if (dout_tvalid) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (flush || req_accept) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // Flush and new requests have no effect here.
                if (dvd_now && dvs_now && dout_tvalid) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Multiply latency counter: loaded on entry, decremented while waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            mul_cnt <= 3'd0;
        end else if (state_nxt == ST_MUL_WAIT) begin
            mul_cnt <= (state == ST_MUL_WAIT) ? (mul_cnt - 3'd1) : MUL_LOAD;
        end else begin
            mul_cnt <= 3'd0;
        end
    end

    // Per-channel accepted flags; cleared whenever the controller is or
    // becomes idle so every divide starts with both channels pending.
    always_ff @(posedge clk) begin
        if (reset || (state == ST_IDLE) || (state_nxt == ST_IDLE)) begin
            dvd_acc <= 1'b0;
            dvs_acc <= 1'b0;
        end else begin
            dvd_acc <= dvd_now;
            dvs_acc <= dvs_now;
        end
    end

    // Divider select: latched from the request kind at divide entry and
    // held until the controller returns to IDLE.
    always_ff @(posedge clk) begin
        if (reset || (state_nxt == ST_IDLE)) begin
            sel_q <= 1'b0;
        end else if ((state == ST_IDLE) && (state_nxt == ST_DIV_ISSUE)) begin
            sel_q <= req_kind[0];
        end
    end

    // Output decode; everything is forced quiet while reset is asserted.
    always_comb begin
        done         = 1'b0;
        busy         = 1'b0;
        sel_unsigned = 1'b0;
        dvd_tvalid   = 1'b0;
        dvs_tvalid   = 1'b0;
        if (!reset) begin
            busy         = (state != ST_IDLE);
            sel_unsigned = sel_q;
            // A flush in the done cycle must not let the result escape.
            done         = (state == ST_DONE) && !flush;
            if ((state == ST_DIV_ISSUE) || (state == ST_DRAIN)) begin
                dvd_tvalid = !dvd_acc;
                dvs_tvalid = !dvs_acc;
            end
        end
    end

endmodule

// File: tb/tb_md_seq_ctrl.sv
// Randomised scoreboard bench for md_seq_ctrl.
// Expected outputs are derived per transaction from its event timeline.
// A monitor pops one expected output vector per cycle and compares.
module tb_md_seq_ctrl;

    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [1:0] req_kind;
    logic       req_accept;
    logic       flush;
    logic       done;
    logic       busy;
    logic       sel_unsigned;
    logic       dvd_tvalid;
    logic       dvs_tvalid;
    logic       dvd_tready;
    logic       dvs_tready;
    logic       dout_tvalid;

    typedef struct packed {
        logic done;
        logic busy;
        logic sel;
        logic dvd;
        logic dvs;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    md_seq_ctrl #(.MUL_LAT(LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_kind     (req_kind),
        .req_accept   (req_accept),
        .flush        (flush),
        .done         (done),
        .busy         (busy),
        .sel_unsigned (sel_unsigned),
        .dvd_tvalid   (dvd_tvalid),
        .dvs_tvalid   (dvs_tvalid),
        .dvd_tready   (dvd_tready),
        .dvs_tready   (dvs_tready),
        .dout_tvalid  (dout_tvalid)
    );

    // Monitor: compare DUT outputs against the next expected vector.
    initial begin
        exp_t  e;
        exp_t  a;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = {done, busy, sel_unsigned, dvd_tvalid, dvs_tvalid};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s t=%0t: done/busy/sel/dvd/dvs got %b expected %b",
                             nm, $time, a, e);
                end
            end
        end
    end

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Drive one cycle of inputs and queue the outputs expected in that cycle.
    task automatic step(input logic rst, input logic rv, input logic [1:0] rk,
                        input logic acc, input logic fl, input logic dr,
                        input logic sr, input logic dv, input exp_t e,
                        input string nm);
        reset       = rst;
        req_valid   = rv;
        req_kind    = rk;
        req_accept  = acc;
        flush       = fl;
        dvd_tready  = dr;
        dvs_tready  = sr;
        dout_tvalid = dv;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // Idle traffic: no request, kind 00 requests, or requests killed by flush.
    task automatic run_idle(input int n, input string nm);
        for (int c = 0; c < n; c++) begin
            int         mode;
            logic       rv;
            logic [1:0] rk;
            logic       fl;
            mode = $urandom_range(0, 2);
            rv   = (mode != 0) ? 1'b1 : rbit();
            rk   = (mode == 1) ? 2'b00 : 2'($urandom_range(0, 3));
            fl   = (mode == 2) ? 1'b1 : 1'b0;
            if (mode == 0) rv = 1'b0;
            step(1'b0, rv, rk, rbit(), fl, rbit(), rbit(), rbit(), 5'b0, nm);
        end
    endtask

    // Multiply transaction starting at cycle 0 in IDLE.
    // d: cycles between first done and req_accept; f: flush cycle; r: reset cycle.
    task automatic run_mul(input int d, input int f, input int r, input string nm);
        int endc;
        int eff_end;
        int last;
        endc    = (f >= 0) ? f + 1 : LAT + d + 1;
        eff_end = (r >= 0 && r < endc) ? r : endc;
        last    = (r >= 0) ? r : endc - 1;
        for (int c = 0; c <= last; c++) begin
            exp_t       e;
            logic       rv;
            logic [1:0] rk;
            logic       acc;
            rv  = (c == 0) ? 1'b1 : rbit();
            rk  = (c == 0) ? 2'b01 : 2'($urandom_range(0, 3));
            acc = (c == LAT + d) || (c >= 1 && c < LAT && rbit());
            e.busy = (c >= 1) && (c < eff_end);
            e.done = (c >= LAT) && (c < eff_end) && (c != f);
            e.sel  = 1'b0;
            e.dvd  = 1'b0;
            e.dvs  = 1'b0;
            step(c == r, rv, rk, acc, c == f, rbit(), rbit(), rbit(), e, nm);
        end
    endtask

    // Divide transaction starting at cycle 0 in IDLE.
    // a/b: cycle each operand's tready first rises; w: extra wait before dout;
    // d: done-to-accept gap; f: flush cycle; r: reset cycle.
    task automatic run_div(input logic u, input int a, input int b, input int w,
                           input int d, input int f, input int r, input string nm);
        int mx;
        int m;
        int endc;
        int eff_end;
        int last;
        bit neither;
        bit drain;
        mx      = (a > b) ? a : b;
        m       = mx + 1 + w;                 // dout_tvalid cycle
        neither = (f >= 1) && (f < a) && (f < b);
        drain   = (f >= 1) && (f <= m) && !neither;
        if (f < 0)        endc = m + 2 + d;
        else if (neither) endc = f + 1;
        else if (f <= m)  endc = m + 1;
        else              endc = f + 1;
        eff_end = (r >= 0 && r < endc) ? r : endc;
        last    = (r >= 0) ? r : endc - 1;
        for (int c = 0; c <= last; c++) begin
            exp_t       e;
            logic       rv;
            logic [1:0] rk;
            logic       acc;
            logic       fl;
            logic       dr;
            logic       sr;
            rv  = (c == 0) ? 1'b1 : rbit();
            rk  = (c == 0) ? {1'b1, u} : 2'($urandom_range(0, 3));
            dr  = (c == a) || (c > a && rbit());
            sr  = (c == b) || (c > b && rbit());
            acc = (c == m + 1 + d) || (c >= 1 && c <= m && rbit());
            fl  = (c == f) || (drain && c > f && c <= m && rbit());
            e.busy = (c >= 1) && (c < eff_end);
            e.sel  = u && e.busy;
            e.dvd  = (c >= 1) && (c <= a) && (c < eff_end);
            e.dvs  = (c >= 1) && (c <= b) && (c < eff_end);
            e.done = (c >= m + 1) && (c < eff_end) && (c != f);
            step(c == r, rv, rk, acc, fl, dr, sr, c == m, e, nm);
        end
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_kind    = 2'b00;
        req_accept  = 1'b0;
        flush       = 1'b0;
        dvd_tready  = 1'b0;
        dvs_tready  = 1'b0;
        dout_tvalid = 1'b0;
        @(posedge clk);
        #1;
        // Reset held with noisy inputs: all outputs quiet.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 2'($urandom_range(0, 3)), rbit(), rbit(),
                 rbit(), rbit(), rbit(), 5'b0, "reset_hold");
        end
        run_idle(6, "idle_noise");

        run_mul(2, -1, -1, "mul_basic");
        run_div(1'b0, 1, 3, 6, 0, -1, -1, "div_signed");
        run_div(1'b1, 1, 2, 9, 1, 5, -1, "div_flush_wait");
        run_div(1'b0, 1, 5, 3, 1, 3, -1, "div_flush_issue_one");
        run_mul(0, -1, -1, "b2b_mul");
        run_div(1'b1, 2, 1, 1, 0, -1, -1, "b2b_div");
        run_div(1'b1, 1, 1, 5, 0, -1, 4, "div_reset_wait");
        run_idle(5, "idle_after_reset");
        run_div(1'b0, 2, 1, 2, 0, 5, -1, "div_flush_with_dout");
        run_div(1'b1, 3, 4, 1, 0, 2, -1, "div_flush_issue_none");
        run_mul(1, 1, -1, "mul_flush_wait");
        run_mul(3, LAT + 1, -1, "mul_flush_done");
        run_div(1'b0, 2, 2, 0, 0, 2, -1, "div_flush_both_same");

        for (int t = 0; t < 150; t++) begin
            int pick;
            int a;
            int b;
            int w;
            int d;
            int m;
            int f;
            int r;
            pick = $urandom_range(0, 9);
            d    = $urandom_range(0, 3);
            f    = -1;
            r    = -1;
            if (pick < 2) begin
                run_idle($urandom_range(1, 4), "rand_idle");
            end else if (pick < 5) begin
                if ($urandom_range(0, 3) == 0) f = $urandom_range(1, LAT + d);
                else if ($urandom_range(0, 7) == 0) r = $urandom_range(1, LAT + d);
                run_mul(d, f, r, "rand_mul");
            end else begin
                a = $urandom_range(1, 4);
                b = $urandom_range(1, 4);
                w = $urandom_range(0, 4);
                m = ((a > b) ? a : b) + 1 + w;
                if ($urandom_range(0, 2) == 0) f = $urandom_range(1, m + 1 + d);
                else if ($urandom_range(0, 7) == 0) r = $urandom_range(1, m + 1 + d);
                run_div(rbit(), a, b, w, d, f, r, "rand_div");
            end
        end

        run_idle(3, "idle_tail");
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
